// File: rtl/bus_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_mem
// Purpose  : Burst bus slave backed by a 2^ADDR_BITS x 32 single-port RAM.
//            Define BUS_SLAVE_ERROR_EN to flag excess write beats as a bus error.
// Revision : 1.0 - initial release
// ============================================================================
module bus_slave_mem #(
    parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
    parameter int          ADDR_BITS = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_transaction_in,
    input  logic [31:0] address_data_in,
    input  logic        read_n_write_in,
    input  logic [7:0]  burst_size_in,
    input  logic        data_valid_in,
    input  logic        end_transaction_in,
    output logic [31:0] address_data_out,
    output logic        data_valid_out,
    output logic        end_transaction_out,
    output logic        busy_out,
    output logic        error_out
);

    localparam int c_DEPTH = 1 << ADDR_BITS;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_WSETUP    = 3'd1;
    localparam logic [2:0] c_WRITE     = 3'd2;
    localparam logic [2:0] c_RPREFETCH = 3'd3;
    localparam logic [2:0] c_READ      = 3'd4;
    localparam logic [2:0] c_RDONE     = 3'd5;

    logic [2:0]           r_state;
    logic [ADDR_BITS-1:0] r_ptr;
    logic [8:0]           r_beats;
    logic [31:0]          r_mem [0:c_DEPTH-1];
    logic [31:0]          r_ram_q;
    logic [31:0]          r_data_out;
    logic                 r_valid_out;
    logic                 r_end_out;
    logic                 r_busy;

    logic                 w_sel;
    logic                 w_start;
    logic [ADDR_BITS-1:0] w_word;
    logic [ADDR_BITS-1:0] w_ram_addr;
    logic                 w_ram_we;

    assign w_sel   = (address_data_in[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    assign w_start = begin_transaction_in && w_sel && (r_state == c_IDLE);
    assign w_word  = address_data_in[ADDR_BITS+1:2];

    // The RAM is addressed straight from the bus in IDLE so the first read
    // word is already fetched by the time RPREFETCH registers it out.
    assign w_ram_addr = (r_state == c_IDLE) ? w_word : r_ptr;
    assign w_ram_we   = (r_state == c_WRITE) && data_valid_in && !r_busy && (r_beats != 9'd0);

    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= address_data_in;
        end
        r_ram_q <= r_mem[w_ram_addr];
    end

`ifdef BUS_SLAVE_ERROR_EN
    logic w_excess;
    logic r_err;

    assign w_excess = (r_state == c_WRITE) && data_valid_in && (r_beats == 9'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_excess;
        end
    end

    assign error_out = r_err;
`else
    assign error_out = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_ptr       <= '0;
            r_beats     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_end_out   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_end_out   <= 1'b0;
            r_busy      <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_beats <= {1'b0, burst_size_in} + 9'd1;
                        if (read_n_write_in) begin
                            r_state <= c_RPREFETCH;
                            r_ptr   <= w_word + ADDR_BITS'(1);
                        end else begin
                            r_state <= c_WSETUP;
                            r_ptr   <= w_word;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                c_WSETUP: begin
                    r_state <= c_WRITE;
                end
                c_WRITE: begin
                    if (w_ram_we) begin
                        r_ptr   <= r_ptr + ADDR_BITS'(1);
                        r_beats <= r_beats - 9'd1;
                    end
`ifdef BUS_SLAVE_ERROR_EN
                    if (w_excess) begin
                        r_end_out <= 1'b1;
                        r_state   <= c_IDLE;
                    end else if (end_transaction_in) begin
                        r_state <= c_IDLE;
                    end
`else
                    if (end_transaction_in) begin
                        r_state <= c_IDLE;
                    end
`endif
                end
                c_RPREFETCH, c_READ: begin
                    if (end_transaction_in) begin
                        r_state <= c_IDLE;
                    end else if (r_beats != 9'd0) begin
                        r_data_out  <= r_ram_q;
                        r_valid_out <= 1'b1;
                        r_ptr       <= r_ptr + ADDR_BITS'(1);
                        r_beats     <= r_beats - 9'd1;
                        r_state     <= c_READ;
                    end else begin
                        r_end_out <= 1'b1;
                        r_state   <= c_RDONE;
                    end
                end
                c_RDONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign address_data_out    = r_data_out;
    assign data_valid_out      = r_valid_out;
    assign end_transaction_out = r_end_out;
    assign busy_out            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_slave_mem
// Purpose  : Scoreboard bench for bus_slave_mem with a word-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_slave_mem;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        begin_transaction_in = 1'b0;
    logic [31:0] address_data_in = '0;
    logic        read_n_write_in = 1'b0;
    logic [7:0]  burst_size_in = '0;
    logic        data_valid_in = 1'b0;
    logic        end_transaction_in = 1'b0;
    logic [31:0] address_data_out;
    logic        data_valid_out;
    logic        end_transaction_out;
    logic        busy_out;
    logic        error_out;

    bus_slave_mem dut (
        .clock               (clock),
        .reset               (reset),
        .begin_transaction_in(begin_transaction_in),
        .address_data_in     (address_data_in),
        .read_n_write_in     (read_n_write_in),
        .burst_size_in       (burst_size_in),
        .data_valid_in       (data_valid_in),
        .end_transaction_in  (end_transaction_in),
        .address_data_out    (address_data_out),
        .data_valid_out      (data_valid_out),
        .end_transaction_out (end_transaction_out),
        .busy_out            (busy_out),
        .error_out           (error_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // kinds: 0 busy, 1 read beat, 2 end, 3 error (data = end_transaction_out)
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] wdata_q[$];
    logic [31:0] mem [512];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input bit ok, input string name, input string act, input string req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, required %s (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic string kname(input int k);
        case (k)
            0: return "busy";
            1: return "beat";
            2: return "end";
            default: return "error";
        endcase
    endfunction

    function automatic void expect_ev(input int kind, input int c, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic observe(input int kind, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0 || exp_q[0].cyc > cyc) begin
            check(1'b0, "unexpected_event", $sformatf("%s data %h", kname(kind), d), "no event");
        end else begin
            e = exp_q.pop_front();
            check(e.kind == kind && e.cyc == cyc && e.data == d, {"event_", kname(e.kind)},
                  $sformatf("%s data %h at cycle %0d", kname(kind), d, cyc),
                  $sformatf("%s data %h at cycle %0d", kname(e.kind), e.data, e.cyc));
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    check(1'b0, "missed_event", "nothing",
                          $sformatf("%s data %h at cycle %0d", kname(exp_q[0].kind), exp_q[0].data, exp_q[0].cyc));
                    void'(exp_q.pop_front());
                end
                if (busy_out) observe(0, '0);
                if (data_valid_out) observe(1, address_data_out);
                if (error_out) observe(3, {31'd0, end_transaction_out});
                else if (end_transaction_out) observe(2, '0);
                if (!data_valid_out)
                    check(address_data_out == '0, "data_zero_when_invalid",
                          $sformatf("%h", address_data_out), "00000000");
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        begin_transaction_in = 1'b0;
        address_data_in      = '0;
        read_n_write_in      = 1'b0;
        burst_size_in        = '0;
        data_valid_in        = 1'b0;
        end_transaction_in   = 1'b0;
    endtask

    function automatic logic [31:0] baddr(input int w);
        return 32'h5000_0000 | (32'(w) << 2) | 32'($urandom_range(0, 3));
    endfunction

    task automatic junk_begin();
        begin_transaction_in = 1'b1;
        address_data_in      = baddr($urandom_range(0, 511));
        read_n_write_in      = 1'($urandom_range(0, 1));
        burst_size_in        = 8'($urandom);
    endtask

    task automatic check_outputs_zero(input string name);
        check({address_data_out, data_valid_out, end_transaction_out, busy_out, error_out} == '0, name,
              $sformatf("data %h dv %b end %b busy %b err %b", address_data_out, data_valid_out,
                        end_transaction_out, busy_out, error_out), "all zero");
    endtask

    task automatic do_write(input int w, input int burst, input int extra, input bit junk);
        int          n;
        int          p;
        logic [31:0] d;
        n = burst + 1;
        begin_transaction_in = 1'b1;
        address_data_in      = baddr(w);
        read_n_write_in      = 1'b0;
        burst_size_in        = 8'(burst);
        expect_ev(0, cyc + 1, '0);
        tick();
        idle_inputs();
        if (junk) begin
            data_valid_in   = 1'b1;
            address_data_in = $urandom;
        end
        tick();
        p = w;
        for (int i = 0; i < n + extra; i++) begin
            idle_inputs();
            while ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) junk_begin();
                tick();
                idle_inputs();
            end
            d = (wdata_q.size() > 0) ? wdata_q.pop_front() : $urandom;
            data_valid_in   = 1'b1;
            address_data_in = d;
            if (i < n) begin
                mem[p] = d;
                p = (p + 1) % 512;
            end
`ifdef BUS_SLAVE_ERROR_EN
            else begin
                expect_ev(3, cyc + 1, 32'd1);
                tick();
                idle_inputs();
                tick();
                return;
            end
`endif
            if (i == n + extra - 1) end_transaction_in = 1'b1;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    // abort < 0: full burst; otherwise end_transaction_in once abort beats were seen
    task automatic do_read(input int w, input int burst, input int abort);
        int n;
        int b;
        int k;
        int last;
        n = burst + 1;
        b = cyc;
        k = (abort < 0) ? n : abort;
        begin_transaction_in = 1'b1;
        address_data_in      = baddr(w);
        read_n_write_in      = 1'b1;
        burst_size_in        = 8'(burst);
        for (int i = 0; i < k; i++) expect_ev(1, b + 2 + i, mem[(w + i) % 512]);
        if (abort < 0) expect_ev(2, b + 2 + n, '0);
        last = (abort < 0) ? b + 2 + n : b + 1 + abort;
        tick();
        idle_inputs();
        while (cyc <= last) begin
            if ($urandom_range(0, 2) == 0) junk_begin();
            if ($urandom_range(0, 2) == 0) data_valid_in = 1'b1;
            if (abort >= 0 && cyc == last) end_transaction_in = 1'b1;
            tick();
            idle_inputs();
        end
        tick();
    endtask

    task automatic do_unsel(input logic [31:0] a);
        begin_transaction_in = 1'b1;
        address_data_in      = a;
        read_n_write_in      = 1'($urandom_range(0, 1));
        burst_size_in        = 8'($urandom_range(0, 7));
        tick();
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        #1 reset = 1'b1;
        #1 check_outputs_zero("async_reset_outputs");
        @(negedge clock);
        #2 reset = 1'b0;
        tick();
    endtask

    initial begin
        int op;
        int burst;
        idle_inputs();
        #12 check_outputs_zero("reset_state");
        @(negedge clock);
        #2 reset = 1'b0;
        tick();

        do_write(0, 255, 0, 0);
        do_write(256, 255, 0, 0);

        wdata_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(4, 3, 0, 1);
        do_read(4, 3, -1);

        wdata_q = '{32'h0000_00AA, 32'h0000_00BB};
        do_write(511, 1, 0, 0);
        do_read(510, 3, -1);

        do_unsel(32'h6000_0000);
        do_unsel(32'h5000_0800);
        do_unsel(32'h4FFF_FFFC);

        do_read(0, 7, 3);
        do_read(100, 5, 0);
        do_read(200, 2, 3);
        do_write(20, 0, 1, 0);
        do_read(19, 3, -1);

        // reset while busy_out is high: nothing written, nothing reported after
        begin_transaction_in = 1'b1;
        address_data_in      = baddr(300);
        read_n_write_in      = 1'b0;
        burst_size_in        = 8'd3;
        expect_ev(0, cyc + 1, '0);
        tick();
        idle_inputs();
        reset_pulse();
        data_valid_in   = 1'b1;
        address_data_in = $urandom;
        tick();
        idle_inputs();
        tick();

        // reset in the middle of a read burst
        for (int i = 0; i < 2; i++) expect_ev(1, cyc + 2 + i, mem[40 + i]);
        begin_transaction_in = 1'b1;
        address_data_in      = baddr(40);
        read_n_write_in      = 1'b1;
        burst_size_in        = 8'd7;
        tick();
        idle_inputs();
        tick();
        tick();
        reset_pulse();
        do_read(298, 5, -1);

        for (int t = 0; t < 40; t++) begin
            op    = $urandom_range(0, 9);
            burst = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            case (op)
                0, 1, 2: do_write($urandom_range(0, 511), burst, 0, 1'($urandom_range(0, 1)));
                3, 4, 5: do_read($urandom_range(0, 511), burst, -1);
                6, 7:    do_read($urandom_range(0, 511), burst, $urandom_range(0, burst + 1));
                8:       do_write($urandom_range(0, 511), burst, $urandom_range(1, 2), 1'b0);
                default: do_unsel({3'b011, 29'($urandom)});
            endcase
        end

        do_read(0, 255, -1);
        do_read(256, 255, -1);

        repeat (5) tick();
        while (exp_q.size() > 0) begin
            check(1'b0, "missing_at_end", "nothing",
                  $sformatf("%s at cycle %0d", kname(exp_q[0].kind), exp_q[0].cyc));
            void'(exp_q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_slave_mem.md
BUS_SLAVE_MEM -- requirements
Module: bus_slave_mem

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h5000_0000, byte base of the decoded window.
REQ-002 SHALL have parameter ADDR_BITS, default 9, word-address width; the window is 2^ADDR_BITS 32-bit words.
REQ-003 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port begin_transaction_in  in  1  one-cycle start of a bus transaction.
REQ-006 SHALL have port address_data_in  in  32  byte address while begin is high, write data while data_valid_in is high.
REQ-007 SHALL have port read_n_write_in  in  1  1 = read, 0 = write; sampled with begin.
REQ-008 SHALL have port burst_size_in  in  8  beats minus one; sampled with begin.
REQ-009 SHALL have port data_valid_in  in  1  write beat present.
REQ-010 SHALL have port end_transaction_in  in  1  master ends or aborts the transaction.
REQ-011 SHALL have port address_data_out  out  32  read data.
REQ-012 SHALL have port data_valid_out  out  1  read beat present.
REQ-013 SHALL have port end_transaction_out  out  1  one-cycle end of a read burst or error.
REQ-014 SHALL have port busy_out  out  1  write beat not accepted this cycle.
REQ-015 SHALL have port error_out  out  1  one-cycle bus error.

Function
REQ-016 SHALL implement FSM states IDLE, WSETUP, WRITE, RPREFETCH, READ, RDONE.
REQ-017 Select SHALL be address_data_in[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]; begin in IDLE without select SHALL leave the FSM in IDLE with all outputs 0.
REQ-018 On selected begin in IDLE, SHALL capture word pointer = address_data_in[ADDR_BITS+1:2], beat count = burst_size_in+1 (9-bit, 1..256) and direction.
REQ-019 begin_transaction_in outside IDLE SHALL be ignored.
REQ-020 Write: IDLE -> WSETUP; busy_out = 1 in WSETUP only; WSETUP -> WRITE next cycle.
REQ-021 In WRITE, each cycle with data_valid_in = 1 and busy_out = 0 SHALL store address_data_in at the pointer, increment the pointer and count one beat.
REQ-022 The pointer SHALL wrap modulo 2^ADDR_BITS.
REQ-023 WRITE -> IDLE on end_transaction_in; a beat accompanied by end_transaction_in SHALL still be stored.
REQ-024 Read: IDLE -> RPREFETCH (RAM read issued) -> READ; first data_valid_out in the 2nd cycle after begin.
REQ-025 In READ, data_valid_out = 1 every cycle with consecutive words until the beat count is exhausted; then RDONE with end_transaction_out = 1 for one cycle, then IDLE.
REQ-026 end_transaction_in during RPREFETCH or READ SHALL abort: data_valid_out = 0 next cycle, IDLE, no end_transaction_out.
REQ-027 Storage SHALL be a synchronous single-port RAM of 2^ADDR_BITS x 32; all outputs registered.
REQ-028 address_data_out SHALL be 0 whenever data_valid_out = 0.

Reset
REQ-029 Reset SHALL force IDLE, pointer and beat counter 0, and all outputs 0 immediately; RAM contents are not cleared.
REQ-030 Reset mid-transaction SHALL discard the transaction; no outputs asserted until a new begin.

Configuration
REQ-031 Macro BUS_SLAVE_ERROR_EN: when defined, a write beat beyond the beat count SHALL not be stored and SHALL cause error_out = 1 and end_transaction_out = 1 for one cycle, then IDLE.
REQ-032 When BUS_SLAVE_ERROR_EN is undefined, excess write beats SHALL be dropped silently, remaining in WRITE until end_transaction_in; error_out is tied 0.

Verification
REQ-033 Write begin addr 32'h5000_0010, burst 3, data 1..4 -> busy_out 1 for one cycle, words 4..7 = 1..4.
REQ-034 Read begin addr 32'h5000_0010, burst 3 -> data_valid_out cycles 2..5 carry 1..4, end_transaction_out in cycle 6.
REQ-035 Write at word 511, burst 1, data AA, BB -> word 511 = AA, word 0 = BB (wrap).
REQ-036 Begin addr 32'h6000_0000 -> no busy, data_valid or end response; FSM stays IDLE.
REQ-037 Read burst 7 with end_transaction_in in beat 3 -> exactly 3 beats, no end_transaction_out; reset asserted mid-write -> outputs 0 the same cycle.
REQ-038 With BUS_SLAVE_ERROR_EN, write burst 0 followed by 2 beats -> second beat not stored, error_out and end_transaction_out high one cycle.
